// File: rtl/prescaled_updown_counter.sv
// Up/down counter with an integrated prescaler tick, programmable limit, load, and wrap/saturate bounds.
// Define PRESCALED_COUNTER_BCD_EN to count in packed BCD digits instead of binary.
module prescaled_updown_counter #(
    parameter int NUM_CNT_BITS = 16,
    parameter int NUM_DIV_BITS = 22,
    parameter int SATURATE     = 0
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic                    up_down,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic [NUM_CNT_BITS-1:0] limit_val,
    input  logic [NUM_DIV_BITS-1:0] div_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    tick,
    output logic                    wrap_flag,
    output logic                    at_limit
);

    localparam logic [NUM_DIV_BITS-1:0] DIV_ONE = NUM_DIV_BITS'(1);

    logic [NUM_DIV_BITS-1:0] div_cnt;
    logic [NUM_DIV_BITS-1:0] div_eff;
    logic [NUM_DIV_BITS-1:0] div_nxt;
    logic [NUM_CNT_BITS-1:0] cnt_nxt;
    logic                    wrap_nxt;

`ifdef PRESCALED_COUNTER_BCD_EN
    localparam int NUM_DIGITS = NUM_CNT_BITS / 4;

    // Out-of-range nibbles are read as 9 so every step lands back on valid BCD.
    function automatic logic [NUM_CNT_BITS-1:0] bound_val(input logic [NUM_CNT_BITS-1:0] v);
        logic [NUM_CNT_BITS-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    function automatic logic [NUM_CNT_BITS-1:0] step_up(input logic [NUM_CNT_BITS-1:0] v);
        logic [NUM_CNT_BITS-1:0] r;
        logic                    carry;
        r     = bound_val(v);
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_CNT_BITS-1:0] step_down(input logic [NUM_CNT_BITS-1:0] v);
        logic [NUM_CNT_BITS-1:0] r;
        logic                    borrow;
        r      = bound_val(v);
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction
`else
    function automatic logic [NUM_CNT_BITS-1:0] bound_val(input logic [NUM_CNT_BITS-1:0] v);
        return v;
    endfunction

    function automatic logic [NUM_CNT_BITS-1:0] step_up(input logic [NUM_CNT_BITS-1:0] v);
        return v + NUM_CNT_BITS'(1);
    endfunction

    function automatic logic [NUM_CNT_BITS-1:0] step_down(input logic [NUM_CNT_BITS-1:0] v);
        return v - NUM_CNT_BITS'(1);
    endfunction
`endif

    // A terminal value lowered below the current div_cnt still ticks, so the prescaler cannot hang.
    assign div_eff  = (div_val == '0) ? DIV_ONE : div_val;
    assign tick     = (div_cnt >= (div_eff - DIV_ONE));
    assign at_limit = up_down ? (count_out == limit_val) : (count_out == '0);
    assign div_nxt  = (clear || tick) ? '0 : (div_cnt + DIV_ONE);

    always_comb begin
        cnt_nxt  = count_out;
        wrap_nxt = 1'b0;
        if (clear) begin
            cnt_nxt = '0;
        end else if (load) begin
            cnt_nxt = load_val;
        end else if (tick && count_enable) begin
            if (up_down) begin
                if (bound_val(count_out) >= bound_val(limit_val)) begin
                    if (SATURATE == 0) begin
                        cnt_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = step_up(count_out);
                end
            end else begin
                if (count_out == '0) begin
                    if (SATURATE == 0) begin
                        cnt_nxt  = limit_val;
                        wrap_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = step_down(count_out);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_cnt   <= '0;
            count_out <= '0;
            wrap_flag <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            count_out <= cnt_nxt;
            wrap_flag <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Randomized bench for prescaled_updown_counter: wrap and saturate instances against a numeric reference model.
module tb_prescaled_updown_counter;

    localparam int W  = 16;
    localparam int DW = 22;
`ifdef PRESCALED_COUNTER_BCD_EN
    localparam int MODV = 10000;
`else
    localparam int MODV = 1 << W;
`endif

    logic          clk = 1'b0;
    logic          n_rst;
    logic          clear, count_enable, up_down, load;
    logic [W-1:0]  load_val, limit_val;
    logic [DW-1:0] div_val;
    logic [W-1:0]  cnt_w, cnt_s;
    logic          tick_w, tick_s, wrap_w, wrap_s, atl_w, atl_s;

    int n_checks = 0;
    int n_fails  = 0;

    int           m_div;
    logic [W-1:0] m_cnt [2];
    logic         m_wrap [2];

    prescaled_updown_counter #(.NUM_CNT_BITS(W), .NUM_DIV_BITS(DW), .SATURATE(0)) dut_wrap (
        .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable),
        .up_down(up_down), .load(load), .load_val(load_val), .limit_val(limit_val),
        .div_val(div_val), .count_out(cnt_w), .tick(tick_w), .wrap_flag(wrap_w),
        .at_limit(atl_w)
    );

    prescaled_updown_counter #(.NUM_CNT_BITS(W), .NUM_DIV_BITS(DW), .SATURATE(1)) dut_sat (
        .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable),
        .up_down(up_down), .load(load), .load_val(load_val), .limit_val(limit_val),
        .div_val(div_val), .count_out(cnt_s), .tick(tick_s), .wrap_flag(wrap_s),
        .at_limit(atl_s)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

`ifdef PRESCALED_COUNTER_BCD_EN
    function automatic int to_num(input logic [W-1:0] v);
        int r = 0;
        for (int i = W/4 - 1; i >= 0; i--) begin
            int d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] from_num(input int n);
        logic [W-1:0] v = '0;
        int           x = n;
        for (int i = 0; i < W/4; i++) begin
            v[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return v;
    endfunction
`else
    function automatic int to_num(input logic [W-1:0] v);
        return int'(v);
    endfunction

    function automatic logic [W-1:0] from_num(input int n);
        return W'(n);
    endfunction
`endif

    function automatic logic [W-1:0] rand_val();
        if ($urandom_range(0, 2) != 0) return from_num(int'($urandom_range(0, 12)));
        return from_num(int'($urandom % MODV));
    endfunction

    function automatic int eff_div(input logic [DW-1:0] d);
        return (d == '0) ? 1 : int'(d);
    endfunction

    task automatic model_reset();
        m_div = 0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = '0;
            m_wrap[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit tk;
        tk = (m_div >= eff_div(div_val) - 1);
        for (int k = 0; k < 2; k++) begin
            logic [W-1:0] nc = m_cnt[k];
            logic         nw = 1'b0;
            int           cur = to_num(m_cnt[k]);
            if (clear) nc = '0;
            else if (load) nc = load_val;
            else if (tk && count_enable) begin
                if (up_down) begin
                    if (cur >= to_num(limit_val)) begin
                        if (k == 0) begin nc = '0; nw = 1'b1; end
                    end else nc = from_num((cur + 1) % MODV);
                end else begin
                    if (cur == 0) begin
                        if (k == 0) begin nc = limit_val; nw = 1'b1; end
                    end else nc = from_num(cur - 1);
                end
            end
            m_cnt[k]  = nc;
            m_wrap[k] = nw;
        end
        m_div = (clear || tk) ? 0 : m_div + 1;
    endtask

    task automatic check_outputs();
        logic etk;
        etk = (m_div >= eff_div(div_val) - 1);
        chk_val("tick_w", 32'(tick_w), 32'(etk));
        chk_val("tick_s", 32'(tick_s), 32'(etk));
        chk_val("count_w", 32'(cnt_w), 32'(m_cnt[0]));
        chk_val("count_s", 32'(cnt_s), 32'(m_cnt[1]));
        chk_val("wrap_w", 32'(wrap_w), 32'(m_wrap[0]));
        chk_val("wrap_s", 32'(wrap_s), 32'(m_wrap[1]));
        chk_val("at_limit_w", 32'(atl_w), up_down ? 32'(m_cnt[0] == limit_val) : 32'(m_cnt[0] == '0));
        chk_val("at_limit_s", 32'(atl_s), up_down ? 32'(m_cnt[1] == limit_val) : 32'(m_cnt[1] == '0));
    endtask

    // Inputs are set just after a falling edge; this checks, advances the model, and returns at the next falling edge.
    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
        count_enable = 1'b1; up_down = 1'b1; limit_val = '1; div_val = DW'(4);
        model_reset();
        @(negedge clk);
        #1;
        check_outputs();
        chk_val("rst_tick", 32'(tick_w), 32'h0);
        chk_val("rst_count", 32'(cnt_w), 32'h0);
        @(negedge clk);
        n_rst = 1'b1;

        // Prescaler and first steps.
        repeat (3) cycle();
        chk_val("first_tick", 32'(tick_w), 32'h1);
        cycle();
        chk_val("first_step", 32'(cnt_w), 32'h1);
        repeat (8) cycle();
        chk_val("third_step", 32'(cnt_w), 32'h3);

        // Wrap in both directions.
        div_val = DW'(1); limit_val = from_num(5); load_val = from_num(4); load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        chk_val("at_limit_up", 32'(atl_w), 32'h1);
        cycle();
        chk_val("wrap_up_cnt", 32'(cnt_w), 32'h0);
        chk_val("wrap_up_flag", 32'(wrap_w), 32'h1);
        chk_val("sat_hold_hi", 32'(cnt_s), 32'(from_num(5)));
        up_down = 1'b0;
        #1 chk_val("at_limit_dn", 32'(atl_w), 32'h1);
        cycle();
        chk_val("wrap_dn_cnt", 32'(cnt_w), 32'(from_num(5)));
        chk_val("wrap_dn_flag", 32'(wrap_w), 32'h1);

        // Saturate mode.
        limit_val = from_num(3); up_down = 1'b1; clear = 1'b1;
        cycle();
        clear = 1'b0;
        repeat (6) cycle();
        chk_val("sat_top", 32'(cnt_s), 32'(from_num(3)));
        chk_val("sat_nowrap", 32'(wrap_s), 32'h0);
        up_down = 1'b0;
        repeat (6) cycle();
        chk_val("sat_bottom", 32'(cnt_s), 32'h0);

        // Priority on one edge.
        up_down = 1'b1; clear = 1'b1; load = 1'b1; load_val = W'(16'h00AA);
        cycle();
        chk_val("prio_clear", 32'(cnt_w), 32'h0);
        clear = 1'b0; count_enable = 1'b0;
        cycle();
        chk_val("load_only", 32'(cnt_w), 32'h00AA);
        limit_val = from_num(5); load_val = from_num(9);
        cycle();
        load = 1'b0; count_enable = 1'b1; up_down = 1'b0;
        cycle();
        chk_val("load_above_dn", 32'(cnt_w), 32'(from_num(8)));

        // Divider change while mid-way, then asynchronous reset.
        up_down = 1'b1; limit_val = '1; clear = 1'b1;
        cycle();
        clear = 1'b0; div_val = DW'(100); load = 1'b1; load_val = W'(16'h1234);
        cycle();
        load = 1'b0;
        repeat (49) cycle();
        chk_val("no_tick_mid", 32'(tick_w), 32'h0);
        div_val = DW'(2);
        #1 chk_val("div_shrink_tick", 32'(tick_w), 32'h1);
        cycle();
        chk_val("step_after_shrink", 32'(cnt_w), 32'(from_num(to_num(W'(16'h1234)) + 1)));
        div_val = DW'(100);
        repeat (10) cycle();
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        chk_val("async_cnt", 32'(cnt_w), 32'h0);
        chk_val("async_wrap", 32'(wrap_w), 32'h0);
        chk_val("async_tick", 32'(tick_w), 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) cycle();

`ifdef PRESCALED_COUNTER_BCD_EN
        div_val = DW'(1); up_down = 1'b1; limit_val = W'(16'h0100);
        load = 1'b1; load_val = W'(16'h0099);
        cycle();
        load = 1'b0;
        cycle();
        chk_val("bcd_carry", 32'(cnt_w), 32'h0100);
        cycle();
        chk_val("bcd_wrap_cnt", 32'(cnt_w), 32'h0000);
        chk_val("bcd_wrap_flag", 32'(wrap_w), 32'h1);
        load = 1'b1; load_val = W'(16'h0010);
        cycle();
        load = 1'b0; up_down = 1'b0;
        cycle();
        chk_val("bcd_borrow", 32'(cnt_w), 32'h0009);
`endif

        // Randomized traffic.
        div_val = DW'(1);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) div_val = DW'($urandom_range(0, 6));
            if ($urandom_range(0, 39) == 0)
                limit_val = ($urandom_range(0, 3) == 0) ? '1 : from_num(int'($urandom_range(0, 9)));
            if ($urandom_range(0, 7) == 0) up_down = ~up_down;
            clear        = ($urandom_range(0, 39) == 0);
            load         = ($urandom_range(0, 19) == 0);
            load_val     = rand_val();
            count_enable = ($urandom_range(0, 4) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/prescaled_updown_counter.md
# prescaled_updown_counter

Parametrised free-running counter with an integrated prescaler, for driving slow human-visible counts (hex/BCD display digits) from the fast board clock. Unlike a divided-clock arrangement, everything runs on a single clock: the prescaler produces a one-cycle `tick` enable rather than a derived clock. The counter adds up/down direction, a programmable limit, parallel load, and wrap or saturate behaviour. It sits between the push-button/switch inputs and the `hex_display` decoders.

## Interface
Parameters:
- `NUM_CNT_BITS`, 16: width of the count, load and limit values.
- `NUM_DIV_BITS`, 22: width of the prescaler counter and `div_val`.
- `SATURATE`, 0: 0 = wrap at the bounds; 1 = hold at the bounds.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous clear of the count and the prescaler.
- `count_enable` in 1: allows count steps on `tick`.
- `up_down` in 1: step direction; 1 = up, 0 = down.
- `load` in 1: synchronous parallel load.
- `load_val` in NUM_CNT_BITS: value written on `load`.
- `limit_val` in NUM_CNT_BITS: upper bound of the count range.
- `div_val` in NUM_DIV_BITS: number of clock cycles per tick. 0 is treated as 1.
- `count_out` out NUM_CNT_BITS: registered count.
- `tick` out 1: prescaler terminal pulse.
- `wrap_flag` out 1: registered one-cycle pulse after a wrap.
- `at_limit` out 1: count is at the bound in the current direction.

## Operation
- **Prescaler**
  - `div_cnt` runs free from 0 up to `div_eff`−1, then returns to 0. `div_eff` = max(`div_val`, 1).
  - `tick` = (`div_cnt` ≥ `div_eff`−1), combinational from the register.
  - A `div_val` change that makes `div_cnt` already ≥ the new terminal value produces a tick that cycle, and `div_cnt` returns to 0. The prescaler never hangs.
  - The prescaler ignores `count_enable` and `load`.
- **Count priority per cycle:** `clear` > `load` > step.
  - `clear`: `count_out` ← 0, `div_cnt` ← 0, no wrap pulse.
  - `load`: `count_out` ← `load_val`, whatever the state of `tick` or `count_enable`. The value is not clamped to `limit_val`.
  - Step: occurs only when `tick` and `count_enable` are both high.
- **Up step**
  - If `count_out` ≥ `limit_val`: go to 0 and pulse `wrap_flag` (wrap mode), or hold at the current value (saturate mode).
  - Otherwise: +1.
- **Down step**
  - If `count_out` == 0: go to `limit_val` and pulse `wrap_flag` (wrap mode), or hold at 0 (saturate mode).
  - Otherwise: −1.
  - A loaded value above `limit_val` decrements normally.
- **Limit indication:** `at_limit` = `up_down` ? (`count_out` == `limit_val`) : (`count_out` == 0). It is combinational.
- **Arithmetic:** all count arithmetic is modulo 2^NUM_CNT_BITS. `limit_val` = all-ones gives a full binary range.

## Timing
- **Reset values:** `count_out` = 0, `div_cnt` = 0, `wrap_flag` = 0.
  - `tick` = 1 during reset only if `div_eff` = 1.
  - `at_limit` follows its equation (1 if `up_down` = 0).
- **First tick:** the first tick is high during the cycle after the (`div_eff`−1)-th rising edge following reset release. After that, one tick every `div_eff` cycles. With `div_eff` = 1, `tick` is constantly high.
- **Step latency:** a step taken in the cycle where `tick` and `count_enable` are high appears on `count_out` after that edge.
- **Wrap pulse:** `wrap_flag` is high for exactly the cycle following the wrapping edge.
- **Load and clear latency:** both take effect at the next edge. A wrap coincident with `load` or `clear` is suppressed.
- **Reset mid-operation:** asynchronous; all state returns to the reset values immediately, regardless of `clk`.
- **Direction change:** `up_down` is sampled on the step edge only. No pipeline; `up_down` may change every cycle.

## Configuration
- Macro: `PRESCALED_COUNTER_BCD_EN`.
- **Defined:** `count_out`, `load_val` and `limit_val` are interpreted as NUM_CNT_BITS/4 packed BCD digits.
  - NUM_CNT_BITS must be a multiple of 4.
  - An up step increments the least-significant digit. A digit passing 9 becomes 0 and carries into the next digit.
  - A down step turns a digit at 0 into 9 and borrows from the next digit.
  - Bound checks use the BCD values.
  - Loading a non-BCD nibble is a caller error, but the next step must still produce a valid BCD nibble: any nibble > 9 is treated as 9.
- **Undefined:** plain binary counting as described above. No BCD logic is synthesised.

## Test plan
- **Prescaler and first steps.** Release reset with `div_val` = 4, `count_enable` = 1, `up_down` = 1, `limit_val` = 0xFFFF.
  - `tick` pulses every 4 cycles; the first tick is in the cycle after the 3rd edge.
  - `count_out` reads 1, then 2, 3, one step per tick.
- **Wrap in both directions.** Set `div_val` = 1, `limit_val` = 5, `load` 4, then run up.
  - Up: 5, then 0, with `wrap_flag` high for 1 cycle.
  - Switch to down at 0: next value 5 with a wrap pulse.
  - `at_limit` is high at 5 while counting up, and at 0 while counting down.
- **Saturate mode.** Set `SATURATE` = 1, `limit_val` = 3, start from 0 and count up.
  - `count_out` holds at 3 with `wrap_flag` never high.
  - Counting down from 0 holds at 0.
- **Priority on one edge.** Assert `clear`, `load` (`load_val` = 0x00AA) and a tick together.
  - Result is 0.
  - `load` alone with `count_enable` = 0 gives 0x00AA on the next edge.
  - `load_val` = 9 with `limit_val` = 5, then a down step, gives 8.
- **Asynchronous reset mid-count.** At count 0x1234 with `div_cnt` mid-way, pulse `n_rst` low between clock edges.
  - `count_out`, `wrap_flag` and `div_cnt` go to 0 immediately.
  - Changing `div_val` from 100 to 2 while `div_cnt` = 50 gives an immediate tick.
- **BCD mode** (`PRESCALED_COUNTER_BCD_EN` defined). Count up with `limit_val` = 0x0100.
  - Load 0x0099 and step up: 0x0100. Step again: 0x0000 with a wrap pulse.
  - Load 0x0010 and step down: 0x0009.
